systolic_feed_scheduler: RTL and testbench

- Sequences one matrix-multiply job (C = A×B) on the SystolicArray.
- Accepts one K-step beat per handshake: column k of A (M weights) and row k of B (N activations).
- Applies the per-row and per-column diagonal skew, clears the accumulators before the job, counts the drain latency, then flags results valid on Accs_Out.
- Sits between the operand fetch/DMA stage and the SystolicArray instance.

---
 rtl/systolic_feed_scheduler_pkg.sv | 25 ++
 rtl/systolic_feed_scheduler_if.sv | 14 +
 rtl/systolic_feed_scheduler_skew.sv | 41 ++++
 rtl/systolic_feed_scheduler.sv | 157 +++++++++++++++
 tb/tb_systolic_feed_scheduler.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_feed_scheduler_pkg.sv
// Shared types and helpers for the systolic array feed scheduler.
package systolic_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } sched_state_e;

  localparam int unsigned PERF_W = 32;

  function automatic int unsigned drain_cycles(input int unsigned m,
                                               input int unsigned n,
                                               input int unsigned pe_lat);
    return (m - 1) + (n - 1) + 1 + pe_lat;
  endfunction

  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_feed_scheduler_if.sv
// Beat handshake bundle between the operand fetch stage and the scheduler.
interface systolic_feed_scheduler_if #(
  parameter int unsigned M_ROWS = 2,
  parameter int unsigned N_COLS = 2,
  parameter int unsigned DATA_W = 8
);
  logic                     Beat_Valid;
  logic                     Beat_Ready;
  logic [M_ROWS*DATA_W-1:0] Beat_Weights;
  logic [N_COLS*DATA_W-1:0] Beat_Acts;

  modport master (output Beat_Valid, Beat_Weights, Beat_Acts, input Beat_Ready);
  modport slave  (input Beat_Valid, Beat_Weights, Beat_Acts, output Beat_Ready);
endinterface

// File: rtl/systolic_feed_scheduler_skew.sv
// skew_delay_line: DEPTH-stage data+valid delay; DEPTH=0 degenerates to a wire.
module skew_delay_line #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign out_data       = in_data;
    assign out_valid      = in_valid;
  end else begin : g_pipe
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0]             valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= '0;
      end else begin
        data_q[0]  <= in_data;
        valid_q[0] <= in_valid;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          data_q[i]  <= data_q[i-1];
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_feed_scheduler.sv
// Sequences one C=A*B job onto a systolic array: clear, skewed feed, drain, done.
// Optional SA_SCHED_PERF_COUNTERS_EN adds job-cycle and bubble counters.
module systolic_feed_scheduler
  import systolic_sched_pkg::*;
#(
  parameter int unsigned M_ROWS     = 2,
  parameter int unsigned N_COLS     = 2,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned K_W        = 8,
  parameter int unsigned PE_LATENCY = 1
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     Start,
  input  logic [K_W-1:0]           K_Len,
  systolic_feed_scheduler_if.slave beat,
  output logic [M_ROWS-1:0]        Clear_Row,
  output logic [N_COLS-1:0]        Clear_Column,
  output logic [M_ROWS*DATA_W-1:0] Weights_In_Left,
  output logic [M_ROWS-1:0]        Weight_Valids_In_Left,
  output logic [N_COLS*DATA_W-1:0] Acts_In_Top,
  output logic [N_COLS-1:0]        Act_Valids_In_Top,
  output logic                     Busy,
  output logic                     Done
`ifdef SA_SCHED_PERF_COUNTERS_EN
  ,
  output logic [PERF_W-1:0]        Perf_Job_Cycles,
  output logic [PERF_W-1:0]        Perf_Bubbles
`endif
);

  localparam int unsigned DRAIN_CYCLES = drain_cycles(M_ROWS, N_COLS, PE_LATENCY);
  localparam int unsigned DRAIN_W      = $clog2(DRAIN_CYCLES + 1);

  sched_state_e       state, state_next;
  logic [K_W-1:0]     k_len_q;
  logic [K_W-1:0]     beats, beats_next;
  logic [DRAIN_W-1:0] drain_cnt, drain_next;
  logic               beat_ready;
  logic               accept;

  assign beat_ready      = (state == FEED) && (beats < k_len_q);
  assign accept          = beat.Beat_Valid && beat_ready;
  assign beat.Beat_Ready = beat_ready;
  assign Clear_Row       = (state == CLEAR) ? '1 : '0;
  assign Clear_Column    = (state == CLEAR) ? '1 : '0;
  assign Busy            = (state != IDLE);
  assign Done            = (state == DONE);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      k_len_q   <= '0;
      beats     <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      beats     <= beats_next;
      drain_cnt <= drain_next;
      if (state == IDLE && Start) k_len_q <= K_Len;
    end
  end

  always_comb begin
    state_next = state;
    beats_next = beats;
    drain_next = '0;
    case (state)
      IDLE: begin
        beats_next = '0;
        if (Start) state_next = CLEAR;
      end
      CLEAR: state_next = (k_len_q == '0) ? DONE : FEED;
      FEED: begin
        if (accept) begin
          beats_next = beats + K_W'(1);
          if (beats_next == k_len_q) state_next = DRAIN;
        end
      end
      DRAIN: begin
        drain_next = drain_cnt + DRAIN_W'(1);
        if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane r is delayed r cycles by its skew line, then one shared-stage output register.
  for (genvar r = 0; r < M_ROWS; r++) begin : g_row
    logic [DATA_W-1:0] line_in, line_out, out_q;
    logic              line_valid, valid_q;

    assign line_in = accept ? beat.Beat_Weights[lane_lsb(r, DATA_W) +: DATA_W] : '0;

    skew_delay_line #(.DATA_W(DATA_W), .DEPTH(r)) u_line (
      .clk(Clock), .rst_n(Reset_n),
      .in_data(line_in), .in_valid(accept),
      .out_data(line_out), .out_valid(line_valid)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
        out_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        out_q   <= line_out;
        valid_q <= line_valid;
      end
    end

    assign Weights_In_Left[lane_lsb(r, DATA_W) +: DATA_W] = out_q;
    assign Weight_Valids_In_Left[r]                       = valid_q;
  end

  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    logic [DATA_W-1:0] line_in, line_out, out_q;
    logic              line_valid, valid_q;

    assign line_in = accept ? beat.Beat_Acts[lane_lsb(c, DATA_W) +: DATA_W] : '0;

    skew_delay_line #(.DATA_W(DATA_W), .DEPTH(c)) u_line (
      .clk(Clock), .rst_n(Reset_n),
      .in_data(line_in), .in_valid(accept),
      .out_data(line_out), .out_valid(line_valid)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
        out_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        out_q   <= line_out;
        valid_q <= line_valid;
      end
    end

    assign Acts_In_Top[lane_lsb(c, DATA_W) +: DATA_W] = out_q;
    assign Act_Valids_In_Top[c]                       = valid_q;
  end

`ifdef SA_SCHED_PERF_COUNTERS_EN
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Perf_Job_Cycles <= '0;
      Perf_Bubbles    <= '0;
    end else if (state == IDLE && Start) begin
      Perf_Job_Cycles <= '0;
      Perf_Bubbles    <= '0;
    end else begin
      if (state != IDLE)           Perf_Job_Cycles <= Perf_Job_Cycles + PERF_W'(1);
      if (state == FEED && !accept) Perf_Bubbles   <= Perf_Bubbles + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
// Self-checking bench for systolic_feed_scheduler with a downstream systolic array model.
module tb_systolic_feed_scheduler;
  localparam int M     = 2;
  localparam int N     = 2;
  localparam int DW    = 8;
  localparam int KW    = 8;
  localparam int PEL   = 1;
  localparam int KMAX  = 8;
  localparam int H     = 16;
  localparam int DRAIN = (M - 1) + (N - 1) + 1 + PEL;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [KW-1:0]   k_len;
  logic [M-1:0]    clear_row;
  logic [N-1:0]    clear_col;
  logic [M*DW-1:0] w_left;
  logic [M-1:0]    wv_left;
  logic [N*DW-1:0] a_top;
  logic [N-1:0]    av_top;
  logic            busy;
  logic            done;
`ifdef SA_SCHED_PERF_COUNTERS_EN
  logic [31:0]     perf_job;
  logic [31:0]     perf_bub;
`endif

  systolic_feed_scheduler_if #(.M_ROWS(M), .N_COLS(N), .DATA_W(DW)) bif ();

  systolic_feed_scheduler #(
    .M_ROWS(M), .N_COLS(N), .DATA_W(DW), .K_W(KW), .PE_LATENCY(PEL)
  ) dut (
    .Clock(clk), .Reset_n(rst_n), .Start(start), .K_Len(k_len), .beat(bif),
    .Clear_Row(clear_row), .Clear_Column(clear_col),
    .Weights_In_Left(w_left), .Weight_Valids_In_Left(wv_left),
    .Acts_In_Top(a_top), .Act_Valids_In_Top(av_top),
    .Busy(busy), .Done(done)
`ifdef SA_SCHED_PERF_COUNTERS_EN
    , .Perf_Job_Cycles(perf_job), .Perf_Bubbles(perf_bub)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Job stimulus and expected result
  logic [DW-1:0] ga [M][KMAX];
  logic [DW-1:0] gb [KMAX][N];
  int            gexp [M][N];

  // Monitor bookkeeping
  int cyc = 0;
  int ready_cnt, clear_cnt, last_acc_cyc, clear_cyc, done_cyc;
  bit done_seen;
  bit            hv [H];
  logic [DW-1:0] hw [H][M];
  logic [DW-1:0] ha [H][N];

  // Downstream array model: operands flow right/down one PE per cycle
  int                   accs [M][N];
  logic signed [DW-1:0] wp [M][N];
  logic signed [DW-1:0] ap [M][N];
  bit                   wpv [M][N];
  bit                   apv [M][N];

  initial begin
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) begin
        accs[r][c] = 0; wp[r][c] = '0; ap[r][c] = '0; wpv[r][c] = 0; apv[r][c] = 0;
      end
    for (int h = 0; h < H; h++) hv[h] = 0;
  end

  function automatic logic [DW-1:0] row_lane(input int r);
    return w_left[r*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] col_lane(input int c);
    return a_top[c*DW +: DW];
  endfunction

  always @(negedge clk) begin
    logic signed [DW-1:0] w_in, a_in;
    bit                   w_v, a_v, acc;
    logic signed [DW-1:0] nwp [M][N];
    logic signed [DW-1:0] nap [M][N];
    bit                   nwpv [M][N];
    bit                   napv [M][N];
    cyc++;
    if (!rst_n) begin
      check("reset_outputs", {clear_row, clear_col, w_left, wv_left, a_top, av_top,
                              busy, done, bif.Beat_Ready}, 0);
      for (int h = 0; h < H; h++) hv[h] = 0;
    end else begin
      for (int r = 0; r < M; r++) begin
        int idx;
        idx = (cyc - r - 1) % H;
        check($sformatf("row_lane%0d", r), {wv_left[r], row_lane(r)},
              hv[idx] ? {1'b1, hw[idx][r]} : 9'd0);
      end
      for (int c = 0; c < N; c++) begin
        int idx;
        idx = (cyc - c - 1) % H;
        check($sformatf("col_lane%0d", c), {av_top[c], col_lane(c)},
              hv[idx] ? {1'b1, ha[idx][c]} : 9'd0);
      end
      if (bif.Beat_Ready) ready_cnt++;
      if ({clear_row, clear_col} != '0) begin
        clear_cnt++;
        clear_cyc = cyc;
        check("clear_all", {clear_row, clear_col}, {M+N{1'b1}});
      end
      if ({clear_row, clear_col} != '0 || bif.Beat_Ready || done) check("busy_in_job", busy, 1);
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
        for (int r = 0; r < M; r++)
          for (int c = 0; c < N; c++)
            check($sformatf("accs_%0d_%0d", r, c), accs[r][c], gexp[r][c]);
      end
      acc = bif.Beat_Valid && bif.Beat_Ready;
      hv[cyc % H] = acc;
      for (int r = 0; r < M; r++) hw[cyc % H][r] = bif.Beat_Weights[r*DW +: DW];
      for (int c = 0; c < N; c++) ha[cyc % H][c] = bif.Beat_Acts[c*DW +: DW];
      if (acc) last_acc_cyc = cyc;
    end
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) begin
        if (c == 0) begin w_in = row_lane(r); w_v = wv_left[r]; end
        else begin w_in = wp[r][c-1]; w_v = wpv[r][c-1]; end
        if (r == 0) begin a_in = col_lane(c); a_v = av_top[c]; end
        else begin a_in = ap[r-1][c]; a_v = apv[r-1][c]; end
        if (clear_row[r] || clear_col[c]) accs[r][c] = 0;
        else if (w_v && a_v) accs[r][c] = accs[r][c] + (w_in * a_in);
        nwp[r][c] = w_in; nwpv[r][c] = w_v; nap[r][c] = a_in; napv[r][c] = a_v;
      end
    wp = nwp; wpv = nwpv; ap = nap; apv = napv;
  end

  task automatic compute_exp(input int k);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) begin
        gexp[r][c] = 0;
        for (int i = 0; i < k; i++)
          gexp[r][c] = gexp[r][c] + ($signed(ga[r][i]) * $signed(gb[i][c]));
      end
  endtask

  task automatic run_job(input int k, input int gap, input int sa, input int sb,
                         input int abort_at);
    int n, i, gl, feed, bub;
    bit aborted;
    ready_cnt = 0; clear_cnt = 0; done_seen = 0;
    last_acc_cyc = -1; clear_cyc = -1; done_cyc = -1;
    @(posedge clk); #2; start = 1; k_len = KW'(k);
    @(posedge clk); #2; start = 0; k_len = KW'(k + 3);
    n = 0; i = 0; gl = 0; aborted = 0;
    while (!done_seen && n < 200 && !aborted) begin
      if (n == abort_at) begin
        rst_n = 0; bif.Beat_Valid = 0; start = 0;
        #1;
        check("abort_outputs", {clear_row, clear_col, w_left, wv_left, a_top, av_top,
                                done, bif.Beat_Ready}, 0);
        check("abort_busy", busy, 0);
`ifdef SA_SCHED_PERF_COUNTERS_EN
        check("abort_perf", {perf_job, perf_bub}, 0);
`endif
        @(negedge clk); @(posedge clk); #2; rst_n = 1;
        aborted = 1;
      end else begin
        bif.Beat_Weights = KW'($urandom) | (M*DW)'($urandom << 8);
        bif.Beat_Acts    = KW'($urandom) | (N*DW)'($urandom << 8);
        if (gl > 0) begin
          bif.Beat_Valid = 0; gl--;
        end else if (i < k) begin
          bif.Beat_Valid = 1;
          for (int r = 0; r < M; r++) bif.Beat_Weights[r*DW +: DW] = ga[r][i];
          for (int c = 0; c < N; c++) bif.Beat_Acts[c*DW +: DW] = gb[i][c];
        end else bif.Beat_Valid = 0;
        start = (n == sa) || (n == sb);
        @(negedge clk); #1;
        if (bif.Beat_Valid && bif.Beat_Ready) begin i++; gl = gap; end
        n++;
        @(posedge clk); #2;
      end
    end
    bif.Beat_Valid = 0; start = 0;
    if (aborted) return;
    check("done_seen", done_seen, 1);
    check("idle_after_done", {busy, done}, 0);
    feed = (k == 0) ? 0 : k + (k - 1) * gap;
    bub  = (k == 0) ? 0 : (k - 1) * gap;
    check("ready_cycles", ready_cnt, feed);
    check("clear_cycles", clear_cnt, 1);
    if (k == 0) check("done_after_clear", done_cyc - clear_cyc, 1);
    else        check("drain_latency", done_cyc - last_acc_cyc, DRAIN + 1);
`ifdef SA_SCHED_PERF_COUNTERS_EN
    check("perf_job_cycles", perf_job, 2 + feed + ((k == 0) ? 0 : DRAIN));
    check("perf_bubbles", perf_bub, bub);
`endif
  endtask

  typedef struct {
    int k, gap, sa, sb, abort_at, mset;
    int c00, c01, c10, c11;
  } vec_t;

  vec_t vt [7];

  task automatic load_set(input int mset);
    for (int r = 0; r < M; r++)
      for (int i = 0; i < KMAX; i++) begin ga[r][i] = '0; gb[i][r] = '0; end
    if (mset == 0) begin
      ga[0][0] = 8'd1; ga[0][1] = 8'd2; ga[1][0] = 8'd3; ga[1][1] = 8'd4;
    end else begin
      ga[0][0] = 8'hFF; ga[0][1] = 8'd0; ga[1][0] = 8'd0; ga[1][1] = 8'hFF;
    end
    gb[0][0] = 8'd5; gb[0][1] = 8'd6; gb[1][0] = 8'd7; gb[1][1] = 8'd8;
  endtask

  initial begin
    vt[0] = '{2, 0, -1, -1, -1, 0,  19,  22,  43,  50};  // nominal
    vt[1] = '{2, 2, -1, -1, -1, 0,  19,  22,  43,  50};  // bubbles between beats
    vt[2] = '{0, 0, -1, -1, -1, 0,   0,   0,   0,   0};  // empty job
    vt[3] = '{2, 0,  2,  4, -1, 0,  19,  22,  43,  50};  // Start during FEED and DRAIN
    vt[4] = '{2, 2, -1, -1,  2, 0,   0,   0,   0,   0};  // reset mid-FEED
    vt[5] = '{2, 0, -1, -1, -1, 0,  19,  22,  43,  50};  // fresh job after reset
    vt[6] = '{2, 0, -1, -1, -1, 1,  -5,  -6,  -7,  -8};  // signed, back-to-back

    rst_n = 0; start = 0; k_len = '0;
    bif.Beat_Valid = 0; bif.Beat_Weights = '0; bif.Beat_Acts = '0;
    for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) gexp[r][c] = 0;
    repeat (3) @(posedge clk);
    #2; rst_n = 1;

    for (int t = 0; t < 7; t++) begin
      load_set(vt[t].mset);
      gexp[0][0] = vt[t].c00; gexp[0][1] = vt[t].c01;
      gexp[1][0] = vt[t].c10; gexp[1][1] = vt[t].c11;
      run_job(vt[t].k, vt[t].gap, vt[t].sa, vt[t].sb, vt[t].abort_at);
    end

    for (int j = 0; j < 8; j++) begin
      int k, gap;
      k   = $urandom_range(1, 6);
      gap = $urandom_range(0, 2);
      for (int i = 0; i < KMAX; i++) begin
        for (int r = 0; r < M; r++) ga[r][i] = DW'($urandom);
        for (int c = 0; c < N; c++) gb[i][c] = DW'($urandom);
      end
      compute_exp(k);
      run_job(k, gap, -1, -1, -1);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
